// File: rtl/rock_pkg.sv
// Shared FSM state type, default step constants and the frequency step helper
// for the rocking setpoint controller.
package rock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int F_MIN_DEF          = 2;
  localparam int F_MAX_DEF          = 12;
  localparam int F_INIT_DEF         = 6;
  localparam int A_MIN_DEF          = 1;
  localparam int A_MAX_DEF          = 15;
  localparam int A_INIT_DEF         = 8;
  localparam int SETTLE_CYCLES_DEF  = 16;
  localparam int RECOVER_CYCLES_DEF = 64;

  // fmin and fplus together cancel; otherwise step one way and stay inside [lo,hi].
  function automatic logic [3:0] step_clamp(input logic [3:0] v, input logic up,
                                            input logic dn, input logic [3:0] lo,
                                            input logic [3:0] hi);
    if (up && !dn && v < hi) return 4'(v + 4'd1);
    if (dn && !up && v > lo) return 4'(v - 4'd1);
    return v;
  endfunction

endpackage

// File: rtl/rock_timer.sv
// Loadable down-counter with zero flag, used to time the post-change lockout.
module rock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rock_setpoint.sv
// Rocking frequency/amplitude setpoint controller with post-change lockout and
// slow amplitude recovery toward A_INIT while the user is quiet.
//
//   state     | meaning
//   ST_IDLE   | accept commands, run amplitude recovery
//   ST_APPLY  | one cycle; pending freq/amp written out next edge
//   ST_SETTLE | lockout, commands ignored until timer reaches 0
module rock_setpoint
  import rock_pkg::*;
#(
  parameter int F_MIN          = F_MIN_DEF,
  parameter int F_MAX          = F_MAX_DEF,
  parameter int F_INIT         = F_INIT_DEF,
  parameter int A_MIN          = A_MIN_DEF,
  parameter int A_MAX          = A_MAX_DEF,
  parameter int A_INIT         = A_INIT_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fmin,
  input  logic       fplus,
  input  logic       amin,
  output logic [3:0] freq,
  output logic [3:0] amp,
  output logic       upd,
  output logic       busy,
  output logic       limit
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = $clog2(RECOVER_CYCLES) + 1;
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] REC_LAST    = RW'(RECOVER_CYCLES - 1);
  localparam logic [3:0] F_LO = 4'(F_MIN);
  localparam logic [3:0] F_HI = 4'(F_MAX);
  localparam logic [3:0] A_LO = 4'(A_MIN);
  localparam logic [3:0] A_IN = 4'(A_INIT);

  state_t        state, state_nxt;
  logic [3:0]    freq_nxt, amp_nxt, pend_freq, pend_freq_nxt, pend_amp, pend_amp_nxt;
  logic          pend_amin, pend_amin_nxt;
  logic          upd_nxt, busy_nxt, limit_nxt;
  logic [RW-1:0] rec_cnt, rec_nxt;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic          cmd_valid;
  logic [3:0]    tgt_freq, tgt_amp;

  assign cmd_valid = (fmin ^ fplus) | amin;
  assign tgt_freq  = step_clamp(freq, fplus, fmin, F_LO, F_HI);
  assign tgt_amp   = (amin && amp > A_LO) ? 4'(amp - 4'd1) : amp;

  rock_timer #(.W(TW)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt     = state;
    freq_nxt      = freq;
    amp_nxt       = amp;
    upd_nxt       = 1'b0;
    limit_nxt     = 1'b0;
    rec_nxt       = rec_cnt;
    pend_freq_nxt = pend_freq;
    pend_amp_nxt  = pend_amp;
    pend_amin_nxt = pend_amin;
    tmr_load      = 1'b0;
    tmr_dec       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          // a command arriving on the recovery expiry cycle takes priority
          if (rec_cnt == REC_LAST) rec_nxt = '0;
          if (tgt_freq != freq || tgt_amp != amp) begin
            pend_freq_nxt = tgt_freq;
            pend_amp_nxt  = tgt_amp;
            pend_amin_nxt = amin;
            state_nxt     = ST_APPLY;
          end else begin
            limit_nxt = 1'b1;
          end
        end else if (rec_cnt == REC_LAST) begin
          if (amp < A_IN) begin
            amp_nxt = 4'(amp + 4'd1);
            upd_nxt = 1'b1;
            rec_nxt = '0;
          end
        end else begin
          rec_nxt = RW'(rec_cnt + RW'(1));
        end
      end
      ST_APPLY: begin
        freq_nxt  = pend_freq;
        amp_nxt   = pend_amp;
        upd_nxt   = 1'b1;
        tmr_load  = 1'b1;
        state_nxt = ST_SETTLE;
        if (pend_amin) rec_nxt = '0;
      end
      ST_SETTLE: begin
        if (tmr_zero) state_nxt = ST_IDLE;
        else          tmr_dec   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      freq      <= 4'(F_INIT);
      amp       <= A_IN;
      upd       <= 1'b0;
      busy      <= 1'b0;
      limit     <= 1'b0;
      rec_cnt   <= '0;
      pend_freq <= 4'(F_INIT);
      pend_amp  <= A_IN;
      pend_amin <= 1'b0;
    end else begin
      state     <= state_nxt;
      freq      <= freq_nxt;
      amp       <= amp_nxt;
      upd       <= upd_nxt;
      busy      <= busy_nxt;
      limit     <= limit_nxt;
      rec_cnt   <= rec_nxt;
      pend_freq <= pend_freq_nxt;
      pend_amp  <= pend_amp_nxt;
      pend_amin <= pend_amin_nxt;
    end
  end

endmodule

// File: tb/tb_rock_setpoint.sv
// Directed bench for rock_setpoint: timing of apply/settle, saturation,
// amplitude recovery and reset abort, with hand-computed expectations.
module tb_rock_setpoint;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fmin = 1'b0, fplus = 1'b0, amin = 1'b0;
  logic [3:0] freq, amp;
  logic       upd, busy, limit;

  int n_cmp = 0, n_bad = 0;
  int upd_cnt = 0, both_cnt = 0;
  int k, u0, nupd, last, firstupd, first_lim, badint, extra;

  rock_setpoint dut (
    .clk   (clk),
    .reset (reset),
    .fmin  (fmin),
    .fplus (fplus),
    .amin  (amin),
    .freq  (freq),
    .amp   (amp),
    .upd   (upd),
    .busy  (busy),
    .limit (limit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (upd) upd_cnt++;
    if (upd && limit) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fmin = 1'b0; fplus = 1'b0; amin = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_freq", freq, 6);
    chk("rst_amp", amp, 8);
    chk("rst_upd", upd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_limit", limit, 0);

    // single fplus: busy next cycle, update two edges after sampling, 16 settle cycles
    fplus = 1'b1;
    tick();
    fplus = 1'b0;
    chk("t1_busy_apply", busy, 1);
    chk("t1_freq_hold", freq, 6);
    chk("t1_upd_early", upd, 0);
    tick();
    chk("t1_freq", freq, 7);
    chk("t1_upd", upd, 1);
    repeat (15) tick();
    chk("t1_busy_settle", busy, 1);
    chk("t1_upd_once", upd, 0);
    tick();
    chk("t1_busy_done", busy, 0);

    // fmin+fplus cancel, amin still honoured
    do_reset();
    u0 = upd_cnt;
    fmin = 1'b1; fplus = 1'b1; amin = 1'b1;
    tick();
    fmin = 1'b0; fplus = 1'b0; amin = 1'b0;
    tick();
    chk("t2_freq", freq, 6);
    chk("t2_amp", amp, 7);
    chk("t2_upd", upd, 1);
    repeat (20) tick();
    chk("t2_upd_count", upd_cnt - u0, 1);

    // fmin step down
    do_reset();
    fmin = 1'b1;
    tick();
    fmin = 1'b0;
    tick();
    chk("t7_freq", freq, 5);
    chk("t7_upd", upd, 1);

    // saturate at F_MAX
    do_reset();
    fplus = 1'b1;
    k = 0;
    while (!(freq == 4'd12 && !busy) && k < 200) begin
      tick();
      k++;
    end
    chk("t3_reach12", {31'd0, freq == 4'd12 && !busy}, 1);
    tick();
    chk("t3_limit", limit, 1);
    chk("t3_upd", upd, 0);
    chk("t3_busy", busy, 0);
    chk("t3_freq", freq, 12);
    fplus = 1'b0;
    tick();
    chk("t3_limit_one", limit, 0);

    // amin held: one decrement per 18 cycles down to A_MIN, then limit
    do_reset();
    amin = 1'b1;
    nupd = 0; last = -1; firstupd = -1; first_lim = -1; badint = 0;
    for (int t = 1; t <= 160; t++) begin
      tick();
      if (upd) begin
        nupd++;
        if (last >= 0 && t - last != 18) badint++;
        if (last < 0) firstupd = t;
        last = t;
      end
      if (limit && first_lim < 0) first_lim = t;
    end
    amin = 1'b0;
    chk("t4_nupd", nupd, 7);
    chk("t4_first_upd", firstupd, 2);
    chk("t4_period", badint, 0);
    chk("t4_amp", amp, 1);
    chk("t4_first_limit", first_lim, 127);
    chk("t4_freq", freq, 6);

    // recovery after 64 quiet IDLE cycles, then saturated counter
    do_reset();
    amin = 1'b1;
    tick();
    amin = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    chk("t5_idle", busy, 0);
    chk("t5_amp7", amp, 7);
    repeat (63) tick();
    chk("t5_amp_before", amp, 7);
    tick();
    chk("t5_amp_rec", amp, 8);
    chk("t5_upd_rec", upd, 1);
    extra = 0;
    repeat (200) begin
      tick();
      if (upd) extra++;
    end
    chk("t5_quiet_upd", extra, 0);
    chk("t5_amp_final", amp, 8);

    // reset during SETTLE discards everything
    do_reset();
    fplus = 1'b1;
    tick();
    fplus = 1'b0;
    tick();
    chk("t6_freq7", freq, 7);
    repeat (5) tick();
    chk("t6_busy_settle", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_freq", freq, 6);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_upd", upd, 0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    extra = 0;
    repeat (20) begin
      tick();
      if (upd) extra++;
    end
    chk("t6_no_upd", extra, 0);
    chk("t6_freq_final", freq, 6);
    chk("t6_busy_final", busy, 0);

    chk("upd_limit_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rock_setpoint.md
ROCK_SETPOINT -- requirements
Module: rock_setpoint

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  F_MIN 2: lowest rocking-frequency step
  F_MAX 12: highest rocking-frequency step
  F_INIT 6: frequency step after reset
  A_MIN 1: lowest amplitude step
  A_MAX 15: highest amplitude step
  A_INIT 8: amplitude after reset and recovery ceiling
  SETTLE_CYCLES 16: command lockout after each applied change
  RECOVER_CYCLES 64: quiet IDLE cycles per +1 amplitude recovery
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  clock
  reset  in  1  reset, asynchronous, active-high
  fmin  in  1  request frequency -1 (level, active-high)
  fplus  in  1  request frequency +1 (level, active-high)
  amin  in  1  request amplitude -1 (level, active-high)
  freq  out  4  current frequency step to motor driver
  amp  out  4  current amplitude step to motor driver
  upd  out  1  one-cycle strobe: freq/amp just changed
  busy  out  1  high while state != IDLE
  limit  out  1  one-cycle strobe: command rejected at saturation

Function
REQ-003 FSM states SHALL be IDLE, APPLY and SETTLE; all outputs SHALL be registered.
REQ-004 In IDLE, a valid command SHALL exist when (fmin XOR fplus) OR amin; the command SHALL be latched on that edge.
REQ-005 fmin and fplus both high SHALL cancel: no frequency change; amin in the same cycle SHALL still be honoured.
REQ-006 A latched command that changes no register (saturated) SHALL pulse limit for 1 cycle, leave state in IDLE, and assert no upd.
REQ-007 Otherwise the FSM SHALL enter APPLY for exactly 1 cycle; freq/amp SHALL update, with upd=1, in the cycle after APPLY (2 clocks after the sampling edge).
REQ-008 freq SHALL clamp to [F_MIN,F_MAX] and amp to [A_MIN,A_MAX]; freq and amp changes SHALL both be applied when requested together.
REQ-009 On leaving APPLY the FSM SHALL enter SETTLE, loading a down-counter with SETTLE_CYCLES-1; fmin/fplus/amin SHALL be ignored in APPLY and SETTLE.
REQ-010 SETTLE SHALL return to IDLE on the edge where the counter is 0 (SETTLE lasts SETTLE_CYCLES cycles).
REQ-011 Recovery counter SHALL increment each IDLE cycle with no valid command, hold in APPLY/SETTLE, and clear when an amin command is applied.
REQ-012 When the recovery counter reaches RECOVER_CYCLES-1 in IDLE and amp < A_INIT, amp SHALL increment by 1 with upd=1 on the next cycle, no SETTLE entry, and the counter SHALL clear; if amp >= A_INIT the counter SHALL saturate.
REQ-013 A valid command and a recovery expiry in the same cycle: the command SHALL win and the recovery counter SHALL clear.
REQ-014 upd and limit SHALL never both be high in the same cycle.

Reset
REQ-015 Asserted reset SHALL immediately force: state=IDLE, freq=F_INIT, amp=A_INIT, upd=0, busy=0, limit=0, both counters=0.
REQ-016 Reset mid-APPLY or mid-SETTLE SHALL discard the pending command with no upd pulse.
REQ-017 The first command SHALL be sampled on the first rising clk edge after reset deasserts.

Structure
REQ-018 FSM state enum and default step constants SHALL live in shared package rock_pkg.
REQ-019 Settle/recovery timing SHALL be implemented as one sub-module, rock_timer (loadable down-counter with zero flag), instantiated for SETTLE; the recovery counter SHALL stay inline.

Verification
REQ-020 Reset, then fplus 1 cycle -> busy=1 next cycle, freq=7 with upd=1 two clocks after sampling, busy low 16 cycles after APPLY.
REQ-021 fmin+fplus+amin together from reset -> freq stays 6, amp=7, one upd pulse.
REQ-022 freq=12, fplus -> limit pulse, no upd, busy stays 0, freq=12.
REQ-023 amin held continuously -> amp decrements once per 18 cycles (1 APPLY + 16 SETTLE + 1 IDLE) down to 1, then limit pulses, no further change.
REQ-024 amp=7, no inputs for 64 IDLE cycles -> amp=8 with one upd; 200 further quiet cycles -> no change.
REQ-025 Assert reset during SETTLE after fplus -> freq=6, busy=0 immediately; no upd after release.
